// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory-side cache-line responder:
// FSM state encoding, line width and the latency-jitter LFSR constants.
package mem_resp_pkg;

    // Cache-line width; fixed by the D/I cache interface.
    localparam int LINE_W = 128;

    // Width of the line address presented by the caches (byte address >> 4).
    localparam int MEM_ADDR_W = 28;

    // 8-bit Fibonacci LFSR, taps 8,6,5,4 (1-based) -> bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Request sequencing: wait for a request, count down latency, pulse ready.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One LFSR shift: feedback is the XOR of the tapped bits, shifted in at bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] value);
        logic feedback;
        feedback = ^(value & LFSR_TAPS);
        return {value[6:0], feedback};
    endfunction

endpackage

// File: rtl/mem_resp_lfsr.sv
// 8-bit Fibonacci LFSR used to add 0..3 cycles of jitter to each response.
// Advances only when step_i is high; synchronous reset reloads the seed.
module mem_resp_lfsr
    import mem_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step_i,
    output logic [7:0] value_o
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // Next value: shift once per step request, otherwise hold.
    always_comb begin
        value_d = value_q;
        if (step_i) begin
            value_d = lfsr_step(value_q);
        end
    end

    // State register, reloaded with the seed on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= LFSR_SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side end of the 128-bit cache-line interface.
// Accepts one line read or writeback at a time, services it from an internal
// line array after a programmable latency and pulses mem_ready_o for one cycle.
// Optional build macro MEM_RESP_VARLAT_EN: adds 0..3 cycles of LFSR-driven
// latency jitter per request (sub-module mem_resp_lfsr).
module mem_line_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [MEM_ADDR_W-1:0] mem_addr_i,
    input  logic [LINE_W-1:0]     mem_wdata_i,
    output logic [LINE_W-1:0]     mem_rdata_o,
    output logic                  mem_ready_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Wide enough for the worst-case jittered latency (LATENCY + 3).
    localparam int CNT_W = $clog2(LATENCY + 4) + 1;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                op_write_q;
    logic                op_write_d;
    logic [ADDR_W-1:0]   index_q;
    logic [ADDR_W-1:0]   index_d;
    logic [LINE_W-1:0]   wdata_q;
    logic [LINE_W-1:0]   wdata_d;
    logic [LINE_W-1:0]   rdata_q;

    // Line storage; never cleared so that reset leaves memory contents intact.
    logic [LINE_W-1:0]   line_mem [DEPTH];

    logic                accept;
    logic                rd_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   rd_index;
    logic [CNT_W-1:0]    lat_cycles;

    // A request is only looked at while idle; BUSY/RESP ignore the inputs.
    assign accept = (state_q == ST_IDLE) && (mem_read_i || mem_write_i);

    // Address bits above the line index are don't-care: lines alias.
    generate
        if (ADDR_W < MEM_ADDR_W) begin : g_addr_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^mem_addr_i[MEM_ADDR_W-1:ADDR_W];
        end
    endgenerate

`ifdef MEM_RESP_VARLAT_EN
    logic [7:0] lfsr_value;
    logic       unused_lfsr_bits;

    // Jitter source; the current value sets this request's latency and the
    // LFSR then steps on the accepting edge.
    mem_resp_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .step_i  (accept),
        .value_o (lfsr_value)
    );

    assign lat_cycles       = CNT_W'(LATENCY) + CNT_W'(lfsr_value[1:0]);
    assign unused_lfsr_bits = ^lfsr_value[7:2];
`else
    assign lat_cycles = CNT_W'(LATENCY);
`endif

    // Next-state logic for the request FSM, latency counter and latched request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        index_d    = index_q;
        wdata_d    = wdata_q;
        rd_en      = 1'b0;
        // While idle the array read must use the live address so that a
        // single-cycle latency still has data ready in the RESP cycle.
        rd_index   = index_q;

        case (state_q)
            ST_IDLE: begin
                rd_index = mem_addr_i[ADDR_W-1:0];
                if (accept) begin
                    // Write wins when both request lines are high.
                    op_write_d = mem_write_i;
                    index_d    = mem_addr_i[ADDR_W-1:0];
                    wdata_d    = mem_wdata_i;
                    if (lat_cycles == CNT_W'(1)) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                        rd_en   = !mem_write_i;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = lat_cycles - CNT_W'(1);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    // Fetch on the edge entering RESP so data is valid with ready.
                    rd_en   = !op_write_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Writes commit at the end of the RESP cycle, before any later request
    // can be accepted, so a following read sees the new line.
    assign wr_en = (state_q == ST_RESP) && op_write_q;

    // FSM, counter and request latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            index_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            index_q    <= index_d;
            wdata_q    <= wdata_d;
        end
    end

    // Array write port; reset in the RESP cycle aborts the commit.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            line_mem[index_q] <= wdata_q;
        end
    end

    // Registered array read; the result is held until the next read's fetch
    // because the cache samples it the cycle after ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= line_mem[rd_index];
        end
    end

    assign mem_rdata_o = rdata_q;
    assign mem_ready_o = (state_q == ST_RESP);

endmodule
